// File: rtl/reg_wport_arbiter.sv
// Write-port arbiter for the 32x32 register file: round-robin between two requesters
// plus a one-register-per-cycle clear sweep. Optional macro ARB_SKIP_R0_EN (r0 hardwired zero).
module reg_wport_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] Data0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Data1,
    input  logic              Clr_Start,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              Busy,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

`ifdef ARB_SKIP_R0_EN
    localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] CLR_FIRST = '0;
`endif
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    logic [0:0]        state_q, state_d;
    logic              ptr_q, ptr_d;      // last-granted requester
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;

    logic              elig0, elig1, pick1;
    logic              sweeping;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // A request is ignored while its own grant is on the port, so a held level cannot write twice.
    assign elig0    = Req0 & ~gnt0_q;
    assign elig1    = Req1 & ~gnt1_q;
    assign pick1    = elig1 & (~elig0 | ~ptr_q);
    assign sel_addr = pick1 ? Addr1 : Addr0;
    assign sel_data = pick1 ? Data1 : Data0;
    assign sweeping = (state_q == ST_CLEAR) && (w_addr_q != CLR_LAST);

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        wr_d     = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;

        if (sweeping) begin
            w_addr_d = w_addr_q + ADDR_W'(1);
            w_data_d = '0;
            wr_d     = 1'b1;
        end else begin
            // Final sweep edge falls through to arbitration so requests resume without a bubble.
            state_d = ST_IDLE;
            if (Clr_Start && (state_q == ST_IDLE)) begin
                state_d  = ST_CLEAR;
                w_addr_d = CLR_FIRST;
                w_data_d = '0;
                wr_d     = 1'b1;
            end else if (elig0 || elig1) begin
                gnt0_d   = ~pick1;
                gnt1_d   = pick1;
                ptr_d    = pick1;
                w_addr_d = sel_addr;
                w_data_d = sel_data;
`ifdef ARB_SKIP_R0_EN
                wr_d     = (sel_addr != '0);
`else
                wr_d     = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (Reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            wr_q     <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            wr_q     <= wr_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    assign Gnt0      = gnt0_q;
    assign Gnt1      = gnt1_q;
    assign Busy      = (state_q == ST_CLEAR);
    assign W_Addr    = w_addr_q;
    assign W_Data    = w_data_q;
    assign Write_Reg = wr_q;

endmodule

// File: tb/tb_reg_wport_arbiter.sv
// Scoreboard bench for reg_wport_arbiter: the driver queues expected port activity,
// a negedge monitor pops and compares whenever any output is active.
module tb_reg_wport_arbiter;

`ifdef ARB_SKIP_R0_EN
    localparam int   FIRST = 1;
    localparam logic WR0   = 1'b0;
`else
    localparam int   FIRST = 0;
    localparam logic WR0   = 1'b1;
`endif
    localparam int NCLR = 32 - FIRST;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, clr;
    logic [4:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1, busy, wr;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        gnt0;
        logic        gnt1;
        logic        busy;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    reg_wport_arbiter dut (
        .Clk(clk), .Reset(rst),
        .Req0(req0), .Addr0(addr0), .Data0(data0),
        .Req1(req1), .Addr1(addr1), .Data1(data1),
        .Clr_Start(clr),
        .Gnt0(gnt0), .Gnt1(gnt1), .Busy(busy),
        .W_Addr(w_addr), .W_Data(w_data), .Write_Reg(wr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic expect_out(input string name, input logic g0, input logic g1, input logic b,
                              input logic w, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e = '{gnt0: g0, gnt1: g1, busy: b, wr: w, addr: a, data: d};
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Inputs change 1 time unit after the falling edge, clear of both the monitor and the rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: any active output must match the head of the scoreboard.
    initial begin
        exp_t  e;
        exp_t  act;
        string nm;
        forever begin
            @(negedge clk);
            if (gnt0 || gnt1 || busy || wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {60'd0, gnt0, gnt1, busy, wr}, 64'd0);
                end else begin
                    e   = exp_q.pop_front();
                    nm  = name_q.pop_front();
                    act = '{gnt0: gnt0, gnt1: gnt1, busy: busy, wr: wr, addr: w_addr, data: w_data};
                    if (!e.wr) begin
                        act.addr = e.addr;
                        act.data = e.data;
                    end
                    check(nm, {23'd0, act}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expected items pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; clr = 1'b0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        repeat (2) tick();
        check("reset_outputs", {26'd0, gnt0, gnt1, busy, wr, w_addr, w_data}, 64'd0);
        rst = 1'b0;
        tick();

        // Single write; request held through its grant cycle must not write again.
        req0 = 1'b1; addr0 = 5'd5; data0 = 32'h1234_5678;
        expect_out("single_write", 1, 0, 0, 1, 5'd5, 32'h1234_5678);
        tick();
        tick();
        check("no_double_write", {63'd0, wr}, 64'd0);
        req0 = 1'b0;
        tick();

        // Round robin from reset: 0,1,0,1 back-to-back.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        req0 = 1'b1; addr0 = 5'd1; data0 = 32'hAAAA_0001;
        req1 = 1'b1; addr1 = 5'd2; data1 = 32'hBBBB_0002;
        expect_out("rr_g0_a", 1, 0, 0, 1, 5'd1, 32'hAAAA_0001);
        expect_out("rr_g1_a", 0, 1, 0, 1, 5'd2, 32'hBBBB_0002);
        expect_out("rr_g0_b", 1, 0, 0, 1, 5'd3, 32'hAAAA_0003);
        expect_out("rr_g1_b", 0, 1, 0, 1, 5'd4, 32'hBBBB_0004);
        tick(); addr0 = 5'd3; data0 = 32'hAAAA_0003;
        tick(); addr1 = 5'd4; data1 = 32'hBBBB_0004;
        tick(); req0 = 1'b0;
        tick(); req1 = 1'b0;
        tick();

        // Clear sweep with a coincident request; Clr_Start held into CLEAR is ignored.
        clr = 1'b1; req1 = 1'b1; addr1 = 5'd7; data1 = 32'h0000_CAFE;
        for (int i = FIRST; i < 32; i++) expect_out($sformatf("clear_a%0d", i), 0, 0, 1, 1, 5'(i), 32'd0);
        expect_out("gnt1_after_sweep", 0, 1, 0, 1, 5'd7, 32'h0000_CAFE);
        repeat (3) tick();
        clr = 1'b0;
        repeat (NCLR - 2) tick();
        req1 = 1'b0;
        tick();

        // Reset at sweep address 10 aborts the sweep.
        clr = 1'b1;
        for (int i = FIRST; i <= 10; i++) expect_out($sformatf("abort_a%0d", i), 0, 0, 1, 1, 5'(i), 32'd0);
        tick();
        clr = 1'b0;
        repeat (10 - FIRST) tick();
        rst = 1'b1;
        tick();
        check("abort_outputs", {26'd0, gnt0, gnt1, busy, wr, w_addr, w_data}, 64'd0);
        rst = 1'b0;
        tick();
        req0 = 1'b1; addr0 = 5'd9; data0 = 32'hDEAD_BEEF;
        expect_out("post_abort_write", 1, 0, 0, 1, 5'd9, 32'hDEAD_BEEF);
        tick();
        req0 = 1'b0;
        tick();

        // Address-0 request.
        req0 = 1'b1; addr0 = 5'd0; data0 = 32'hA5A5_A5A5;
        expect_out("addr0_write", 1, 0, 0, WR0, 5'd0, 32'hA5A5_A5A5);
        tick();
        req0 = 1'b0;

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_wport_arbiter.md
# reg_wport_arbiter

Shares the single write port of the 32×32 register file between two independent requesters and adds a hardware clear sequencer that zeroes the file one register per cycle. Sits directly in front of the register file's write inputs (`W_Addr`, `W_Data`, `Write_Reg`); read ports are untouched. All outputs are registered, so the register file sees clean, glitch-free write strobes.

## Interface

**Parameters**
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register data width.

**Ports**
- `Clk`, in, 1: sole clock, rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `Req0`, in, 1: requester 0 write request. Level; held until `Gnt0` is seen.
- `Addr0`, in, `ADDR_W`: requester 0 target address. Stable while `Req0` is high.
- `Data0`, in, `DATA_W`: requester 0 write data. Stable while `Req0` is high.
- `Req1`, `Addr1`, `Data1`: same as requester 0, for requester 1.
- `Clr_Start`, in, 1: start a clear sweep. Sampled in IDLE only.
- `Gnt0`, out, 1: one-cycle pulse; requester 0's write is on the port this cycle.
- `Gnt1`, out, 1: one-cycle pulse; requester 1's write is on the port this cycle.
- `Busy`, out, 1: high for every cycle of a clear sweep.
- `W_Addr`, out, `ADDR_W`: register file write address.
- `W_Data`, out, `DATA_W`: register file write data.
- `Write_Reg`, out, 1: register file write enable.

## Operation

**FSM states**
- IDLE: arbitrate requests.
- CLEAR: sweep zeros through the file.

**IDLE, evaluated each rising edge**
- `Clr_Start`=1 has top priority:
  - Go to CLEAR.
  - Register `W_Addr`=first clear address, `W_Data`=0, `Write_Reg`=1.
  - No grant this edge.
- Otherwise, form the eligible set. `Req_k` is eligible only if `Gnt_k` is currently 0; this blocks a double write from a request still held during its grant cycle.
- One requester eligible: grant it.
  - Register `W_Addr`=`Addr_k`, `W_Data`=`Data_k`, `Write_Reg`=1, `Gnt_k`=1.
  - Set the last-granted pointer to k.
- Both eligible: grant the requester that is not the last-granted pointer (round-robin).
- None eligible: `Write_Reg`=0, both `Gnt`=0. `W_Addr` and `W_Data` hold their values.

**CLEAR**
- Each edge advances `W_Addr` by 1 with `W_Data`=0 and `Write_Reg`=1.
- On the edge where `W_Addr`=31, return to IDLE and run the IDLE arbitration on that same edge. Requests resume with no bubble.
- `Clr_Start` is ignored in CLEAR. Requests are held off; no `Gnt` is issued.
- `Busy` is 1 exactly while the state is CLEAR, so it coincides with the clear writes.

**Reset**
- State IDLE, pointer=1 (requester 0 wins the first conflict).
- All outputs 0: `Gnt0`, `Gnt1`, `Busy`, `Write_Reg`, `W_Addr`, `W_Data`.
- Reset during a sweep aborts it immediately; no further clear writes occur.

## Timing

- Request to write latency: 1 cycle. `Req_k` sampled at edge t gives `Write_Reg`/`Gnt_k` high in cycle t..t+1. The register file commits at edge t+1.
- The requester must drop or replace `Req_k`/`Addr_k`/`Data_k` at edge t+1 (the edge ending the `Gnt_k` cycle).
- Throughput:
  - A single requester writes at most every 2 cycles.
  - Two contending requesters alternate every cycle, giving 1 write/cycle total.
- Clear sweep: `Clr_Start` sampled at edge t gives `Busy` high for cycles t..t+32 (32 writes, addresses 0..31). With `ARB_SKIP_R0_EN` it is 31 cycles (addresses 1..31).
- Maximum wait for a requester: 1 arbitration cycle plus any in-progress sweep.

## Configuration

- Macro `ARB_SKIP_R0_EN`.
- Defined (register 0 is hardwired zero):
  - Clear sweep starts at address 1.
  - A granted request with `Addr_k`=0 still pulses `Gnt_k` and updates the pointer, but `Write_Reg` stays 0 for that cycle.
- Undefined:
  - Sweep covers 0..31.
  - Address-0 writes pass through normally.

## Test plan

- Reset, then `Req0`=1, `Addr0`=5, `Data0`=0x12345678 → next cycle `Write_Reg`=1, `W_Addr`=5, `W_Data`=0x12345678, `Gnt0`=1. Holding `Req0` through the `Gnt0` cycle gives no second write in that cycle.
- `Req0` and `Req1` both held continuously from reset, dropping each after its grant and re-raising → grant order 0,1,0,1; `Write_Reg` high every cycle once both sides re-request.
- `Clr_Start`=1 coincident with `Req1`=1 → `Busy` high 32 cycles, `W_Addr` 0→31 with `W_Data`=0. `Gnt1` first appears in the cycle immediately after the address-31 write.
- Reset asserted at sweep address 10 → next cycle all outputs 0, state IDLE. The next request is granted normally.
- With `ARB_SKIP_R0_EN` defined: `Req0` with `Addr0`=0 → `Gnt0`=1, `Write_Reg`=0. A sweep writes addresses 1..31 over 31 `Busy` cycles.
